// File: rtl/axi_lite_regbank.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_regbank
// Description : AXI4-Lite slave register bank with RW, read-only and
//               self-clearing registers. Define AXI_REGBANK_SLVERR_EN to
//               report SLVERR for unmapped/read-only accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_regbank #(
    parameter int                    ADDR_BITS = 32,
    parameter int                    DATA_BITS = 32,
    parameter int                    NUM_REGS  = 16,
    parameter logic [ADDR_BITS-1:0]  BASE_ADDR = '0,
    parameter logic [NUM_REGS-1:0]   RW_MASK   = '1,
    parameter logic [NUM_REGS-1:0]   SC_MASK   = '0
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_aresetn,
    input  logic [ADDR_BITS-1:0]          s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [DATA_BITS-1:0]          s_axi_wdata,
    input  logic [DATA_BITS/8-1:0]        s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [ADDR_BITS-1:0]          s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [DATA_BITS-1:0]          s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic [NUM_REGS*DATA_BITS-1:0] reg_out,
    input  logic [NUM_REGS*DATA_BITS-1:0] reg_in,
    output logic [NUM_REGS-1:0]           wr_pulse,
    output logic [NUM_REGS-1:0]           rd_pulse
);

    localparam int                   c_STRB_BITS = DATA_BITS / 8;
    localparam int                   c_OFF_BITS  = $clog2(c_STRB_BITS);
    localparam logic [ADDR_BITS-1:0] c_NUM_REGS  = ADDR_BITS'(NUM_REGS);

    logic                   r_aw_held, r_w_held, r_bvalid, r_rvalid;
    logic [1:0]             r_bresp, r_rresp;
    logic [ADDR_BITS-1:0]   r_awaddr;
    logic [DATA_BITS-1:0]   r_wdata, r_rdata;
    logic [c_STRB_BITS-1:0] r_wstrb;
    logic [NUM_REGS-1:0]    r_wr_pulse, r_rd_pulse;

    logic                   w_commit, w_wr_map, w_rd_map;
    logic [ADDR_BITS-1:0]   w_wr_idx, w_rd_idx;
    logic [NUM_REGS-1:0]    w_wr_hit, w_rd_hit;
    logic [DATA_BITS-1:0]   w_rd_data;
    logic [1:0]             w_bresp, w_rresp;
    logic [DATA_BITS-1:0]   w_cur [NUM_REGS];

    // Commit exactly once per held address/data pair; bvalid blocks re-commit.
    assign w_commit = r_aw_held & r_w_held & ~r_bvalid;

    assign w_wr_idx = (r_awaddr - BASE_ADDR) >> c_OFF_BITS;
    assign w_rd_idx = (s_axi_araddr - BASE_ADDR) >> c_OFF_BITS;
    assign w_wr_map = (r_awaddr >= BASE_ADDR) && (w_wr_idx < c_NUM_REGS);
    assign w_rd_map = (s_axi_araddr >= BASE_ADDR) && (w_rd_idx < c_NUM_REGS);

    always_comb begin
        w_wr_hit  = '0;
        w_rd_hit  = '0;
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_wr_hit[i] = w_wr_map && (w_wr_idx == ADDR_BITS'(i));
            w_rd_hit[i] = w_rd_map && (w_rd_idx == ADDR_BITS'(i));
            if (w_rd_hit[i])
                w_rd_data = RW_MASK[i] ? w_cur[i] : reg_in[i*DATA_BITS +: DATA_BITS];
        end
    end

`ifdef AXI_REGBANK_SLVERR_EN
    logic w_wr_ro;
    assign w_wr_ro = |(w_wr_hit & ~RW_MASK);
    assign w_bresp = (!w_wr_map || w_wr_ro) ? 2'b10 : 2'b00;
    assign w_rresp = w_rd_map ? 2'b00 : 2'b10;
`else
    assign w_bresp = 2'b00;
    assign w_rresp = 2'b00;
`endif

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= 2'b00;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (s_axi_awvalid && !r_aw_held) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= s_axi_awaddr;
            end
            if (s_axi_wvalid && !r_w_held) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_axi_wdata;
                r_wstrb  <= s_axi_wstrb;
            end
            if (w_commit) begin
                r_bvalid   <= 1'b1;
                r_bresp    <= w_bresp;
                r_wr_pulse <= w_wr_hit;
            end else if (r_bvalid && s_axi_bready) begin
                r_bvalid  <= 1'b0;
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
        end
    end

    // Read data is sampled before any same-edge commit lands, giving pre-write values.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= 2'b00;
            r_rd_pulse <= '0;
        end else begin
            r_rd_pulse <= '0;
            if (s_axi_arvalid && !r_rvalid) begin
                r_rvalid   <= 1'b1;
                r_rdata    <= w_rd_data;
                r_rresp    <= w_rresp;
                r_rd_pulse <= w_rd_hit;
            end else if (r_rvalid && s_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (RW_MASK[i]) begin : g_rw
            logic [DATA_BITS-1:0] r_q, w_nxt;
            always_comb begin
                w_nxt = SC_MASK[i] ? '0 : r_q;
                if (w_commit && w_wr_hit[i]) begin
                    for (int b = 0; b < c_STRB_BITS; b++)
                        if (r_wstrb[b]) w_nxt[b*8 +: 8] = r_wdata[b*8 +: 8];
                end
            end
            always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
                if (!s_axi_aresetn) r_q <= '0;
                else                r_q <= w_nxt;
            end
            assign w_cur[i] = r_q;
        end else begin : g_ro
            assign w_cur[i] = '0;
        end
        assign reg_out[i*DATA_BITS +: DATA_BITS] = w_cur[i];
    end

    assign s_axi_awready = ~r_aw_held;
    assign s_axi_wready  = ~r_w_held;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = ~r_rvalid;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign wr_pulse      = r_wr_pulse;
    assign rd_pulse      = r_rd_pulse;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_regbank.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_regbank
// Description : Directed self-checking bench for axi_lite_regbank; follows
//               AXI_REGBANK_SLVERR_EN for expected error responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_regbank;

    localparam int          c_NR   = 16;
    localparam logic [31:0] c_BASE = 32'h100;
`ifdef AXI_REGBANK_SLVERR_EN
    localparam logic [1:0]  c_ERR  = 2'b10;
`else
    localparam logic [1:0]  c_ERR  = 2'b00;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [31:0]          awaddr, wdata, araddr, rdata;
    logic [3:0]           wstrb;
    logic                 awvalid, awready, wvalid, wready, bvalid, bready;
    logic                 arvalid, arready, rvalid, rready;
    logic [1:0]           bresp, rresp, resp;
    logic [c_NR*32-1:0]   reg_out, reg_in;
    logic [c_NR-1:0]      wr_pulse, rd_pulse;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_lite_regbank #(
        .ADDR_BITS(32), .DATA_BITS(32), .NUM_REGS(c_NR), .BASE_ADDR(c_BASE),
        .RW_MASK(16'hFFF7), .SC_MASK(16'h0001)
    ) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rout(input int i);
        return reg_out[i*32 +: 32];
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [1:0] r);
        int n;
        @(negedge clk);
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("wr_bvalid_seen", 64'(bvalid), 64'd1);
        r = bresp;
        @(negedge clk);
        bready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
        bready = 0; araddr = '0; arvalid = 0; rready = 0; reg_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_bvalid", 64'(bvalid), 0);
        chk("rst_rvalid", 64'(rvalid), 0);
        chk("rst_regs_any", 64'(|reg_out), 0);
        chk("rst_rdata", 64'(rdata), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_readies", {61'd0, awready, wready, arready}, 64'd7);

        // AW+W same cycle, full word to register 1
        awaddr = c_BASE + 32'h4; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
        awvalid = 1; wvalid = 1; bready = 0;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        chk("s1_bvalid_early", 64'(bvalid), 0);
        chk("s1_awready_low", 64'(awready), 0);
        @(negedge clk);
        chk("s1_bvalid", 64'(bvalid), 1);
        chk("s1_bresp", 64'(bresp), 0);
        chk("s1_reg1", 64'(rout(1)), 64'hA5A5A5A5);
        chk("s1_wr_pulse", 64'(wr_pulse), 64'h2);
        @(negedge clk);
        chk("s1_wr_pulse_off", 64'(wr_pulse), 0);
        chk("s1_bvalid_hold", 64'(bvalid), 1);
        bready = 1;
        @(negedge clk);
        chk("s1_bvalid_done", 64'(bvalid), 0);
        chk("s1_awready_back", 64'(awready), 1);
        bready = 0;

        // W leads AW by two cycles, byte-1 strobe into register 2
        wr(c_BASE + 32'h8, 32'h11223344, 4'hF, resp);
        @(negedge clk);
        wdata = 32'h0000BE00; wstrb = 4'h2; wvalid = 1;
        @(negedge clk);
        wvalid = 0;
        chk("s2_wready_low", 64'(wready), 0);
        @(negedge clk);
        awaddr = c_BASE + 32'h8; awvalid = 1;
        @(negedge clk);
        awvalid = 0;
        chk("s2_bvalid_early", 64'(bvalid), 0);
        @(negedge clk);
        chk("s2_bvalid", 64'(bvalid), 1);
        chk("s2_reg2", 64'(rout(2)), 64'h1122BE44);
        bready = 1;
        @(negedge clk);
        chk("s2_bvalid_done", 64'(bvalid), 0);
        bready = 0;
        @(negedge clk);
        chk("s2_single_resp", 64'(bvalid), 0);

        // Read-only register 3 with rready held low
        reg_in[3*32 +: 32] = 32'hCAFEF00D;
        araddr = c_BASE + 32'hC; arvalid = 1; rready = 0;
        @(negedge clk);
        arvalid = 0;
        reg_in[3*32 +: 32] = 32'h0BADBEEF;
        chk("s3_rvalid", 64'(rvalid), 1);
        chk("s3_rdata", 64'(rdata), 64'hCAFEF00D);
        chk("s3_rd_pulse", 64'(rd_pulse), 64'h8);
        chk("s3_rresp", 64'(rresp), 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("s3_rdata_stable", 64'(rdata), 64'hCAFEF00D);
            chk("s3_arready_low", 64'(arready), 0);
        end
        chk("s3_rd_pulse_off", 64'(rd_pulse), 0);
        rready = 1;
        @(negedge clk);
        chk("s3_rvalid_done", 64'(rvalid), 0);
        chk("s3_arready_back", 64'(arready), 1);
        rready = 0;

        // Self-clearing register 0
        awaddr = c_BASE; wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        chk("s4_reg0_pre", 64'(rout(0)), 0);
        @(negedge clk);
        chk("s4_reg0_set", 64'(rout(0)), 1);
        @(negedge clk);
        chk("s4_reg0_clr", 64'(rout(0)), 0);
        bready = 0;

        // Unmapped read and error responses
        araddr = c_BASE + 32'h40; arvalid = 1; rready = 1;
        @(negedge clk);
        arvalid = 0;
        chk("s5_rvalid", 64'(rvalid), 1);
        chk("s5_rdata", 64'(rdata), 0);
        chk("s5_rresp", 64'(rresp), 64'(c_ERR));
        chk("s5_rd_pulse", 64'(rd_pulse), 0);
        @(negedge clk);
        chk("s5_rvalid_done", 64'(rvalid), 0);
        rready = 0;
        wr(c_BASE + 32'h40, 32'hFFFFFFFF, 4'hF, resp);
        chk("s5_unmapped_bresp", 64'(resp), 64'(c_ERR));
        wr(c_BASE + 32'hC, 32'hFFFFFFFF, 4'hF, resp);
        chk("s5_ro_bresp", 64'(resp), 64'(c_ERR));
        chk("s5_ro_untouched", 64'(rout(3)), 0);

        // Read capturing on the same edge as a write commit to register 5
        wr(c_BASE + 32'h14, 32'h00000055, 4'hF, resp);
        @(negedge clk);
        awaddr = c_BASE + 32'h14; wdata = 32'h00000077; wstrb = 4'hF;
        awvalid = 1; wvalid = 1; bready = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        araddr = c_BASE + 32'h14; arvalid = 1; rready = 0;
        @(negedge clk);
        arvalid = 0;
        chk("s6_rdata_prewrite", 64'(rdata), 64'h55);
        chk("s6_reg5_new", 64'(rout(5)), 64'h77);
        chk("s6_pulses", {32'd0, wr_pulse, rd_pulse}, {32'd0, 16'h0020, 16'h0020});
        rready = 1;
        @(negedge clk);
        chk("s6_rvalid_done", 64'(rvalid), 0);
        rready = 0; bready = 0;

        // Reset with a pending B response
        awaddr = c_BASE + 32'h18; wdata = 32'h66666666; wstrb = 4'hF;
        awvalid = 1; wvalid = 1; bready = 0;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        @(negedge clk);
        chk("s7_bvalid_pending", 64'(bvalid), 1);
        rst_n = 0;
        #1;
        chk("s7_bvalid_rst", 64'(bvalid), 0);
        chk("s7_regs_rst", 64'(|reg_out), 0);
        chk("s7_pulse_rst", 64'(wr_pulse), 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("s7_readies", {61'd0, awready, wready, arready}, 64'd7);
        wr(c_BASE + 32'h1C, 32'h12345678, 4'hF, resp);
        chk("s7_new_bresp", 64'(resp), 0);
        chk("s7_new_reg7", 64'(rout(7)), 64'h12345678);
        chk("s7_reg6_abandoned", 64'(rout(6)), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_regbank.md
AXI_LITE_REGBANK -- requirements
Module: axi_lite_regbank

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_BITS, 32, AXI address width.
- DATA_BITS, 32, register and data width; 32 or 64.
- NUM_REGS, 16, register count, 1..256.
- BASE_ADDR, 0, byte address of register 0.
- RW_MASK, all ones, bit i=1: register i writable; 0: read-only, sourced from reg_in.
- SC_MASK, 0, bit i=1: register i self-clearing; ignored where RW_MASK bit is 0.
REQ-002 Clock and reset SHALL be s_axi_aclk (in, 1, clock) and s_axi_aresetn (in, 1); the block uses one clock and reset is asynchronous, active-low.
REQ-003 AXI-lite slave ports SHALL be s_axi_aw{addr,valid,ready}, s_axi_w{data,strb,valid,ready}, s_axi_b{resp,valid,ready}, s_axi_ar{addr,valid,ready} and s_axi_r{data,resp,valid,ready}; addr is ADDR_BITS, data is DATA_BITS, strb is DATA_BITS/8, resp is 2.
REQ-004 reg_out (out, NUM_REGS*DATA_BITS): flattened register contents; register i occupies slice [i*DATA_BITS +: DATA_BITS].
REQ-005 reg_in (in, NUM_REGS*DATA_BITS): read-only register sources.
REQ-006 wr_pulse (out, NUM_REGS) and rd_pulse (out, NUM_REGS): one-cycle strobes per register.

Function
REQ-007 Register index SHALL be (addr-BASE_ADDR)>>log2(DATA_BITS/8); the address is mapped iff addr>=BASE_ADDR and index<NUM_REGS; low byte-offset bits are ignored.
REQ-008 Address and data acceptance:
- AW and W SHALL be accepted independently.
- awready is high while no write address is held; wready is high while no write data is held.
- Each drops the cycle after its own handshake.
REQ-009 Write commit and response:
- The write SHALL commit on the first edge where both address and data are held.
- bvalid rises on that same edge; both-in-same-cycle gives bvalid exactly one cycle after the handshake.
REQ-010 Commit SHALL update only the bytes whose wstrb bit is set, only on mapped RW registers, and pulse wr_pulse[index] for one cycle.
REQ-011 bvalid SHALL hold until bready; awready and wready reassert on the edge after the B handshake; at most one write is outstanding.
REQ-012 Read timing:
- arready is high when idle and drops after the AR handshake.
- rdata/rvalid are registered one cycle after the AR handshake; rd_pulse[index] pulses in that cycle.
- rvalid holds with stable rdata until rready.
- arready reasserts the cycle after the R handshake.
REQ-013 Read data source:
- RW register: current contents.
- RO register: reg_in slice sampled at the AR-handshake edge.
- Unmapped address: zero.
REQ-014 A self-clearing register SHALL hold written bytes for exactly one cycle after commit, then return to zero.
REQ-015 Read/write collision: a read capturing on the same edge as a write commit to the same register SHALL return the pre-write value.
REQ-016 Read and write channels SHALL operate concurrently without mutual stall.

Reset
REQ-017 On s_axi_aresetn low, asynchronously:
- All registers and rdata = 0.
- bvalid, rvalid, wr_pulse, rd_pulse = 0.
- bresp, rresp = 2'b00.
- awready, wready, arready = 1 after release.
REQ-018 Reset mid-transaction SHALL abandon the transaction with no commit and no response.

Configuration
REQ-019 Macro AXI_REGBANK_SLVERR_EN selects error reporting.
- Defined: writes to unmapped or read-only addresses return bresp=2'b10; unmapped reads return rresp=2'b10 with rdata=0.
- Undefined: all responses are 2'b00.
- Register side effects are identical either way.

Verification
REQ-020 The bench SHALL cover these directed scenarios, each as stimulus -> required response:
- AW+W same cycle to BASE+0x4, data 0xA5A5A5A5, strb 0xF -> bvalid next cycle, reg_out[1]=0xA5A5A5A5, wr_pulse[1] one cycle.
- W two cycles before AW, strb 0x2, data 0x0000BE00 to reg 2 holding 0x11223344 -> reg 2 = 0x1122BE44, one B response.
- reg_in[3]=0xCAFEF00D (RO), read BASE+0xC with rready low 3 cycles -> rdata stable 0xCAFEF00D, arready low until the R handshake.
- Write 0x1 to SC register 0 -> reg_out[0]=1 for exactly one cycle, then 0.
- Read BASE+4*NUM_REGS with the macro defined -> rresp=2'b10, rdata=0; without the macro -> rresp=2'b00.
- Reset asserted with bvalid high and bready low -> bvalid=0, registers=0, and a new write completes normally.
